// File: rtl/irq_enc_pkg.sv
// rtl/irq_enc_pkg.sv - shared sizes, state encoding and clear-mask helper for irq_encoder8x3
package irq_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot3(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_sel8.sv
// rtl/prio_sel8.sv - combinational 8-way selector, fixed (7 highest) or rotating downward from start
module prio_sel8
  import irq_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  mask,
  input  logic [CODE_W-1:0] start,
  input  logic              rr,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  logic [CODE_W-1:0] first;
  logic [CODE_W-1:0] k;

  // Both policies are a downward wrapping scan; fixed priority just always starts at 7.
  always_comb begin
    first = rr ? start : CODE_W'(N_REQ - 1);
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = first - CODE_W'(i);
      if (!found && mask[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder8x3.sv
// rtl/irq_encoder8x3.sv - falling-edge request capture, priority encode, valid/ready offer
module irq_encoder8x3
  import irq_enc_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req_l,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N_REQ-1:0]  pend,
  output logic              gs
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  req_l_q;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] last_grant_q, last_grant_d;

  logic [N_REQ-1:0]  fall;
  logic [N_REQ-1:0]  clr;
  logic              hs;
  logic [N_REQ-1:0]  sel_mask;
  logic [CODE_W-1:0] sel_start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_found;

  // Set wins over clear so an event landing on the accepting cycle is kept.
  always_comb begin
    fall      = req_l_q & ~req_l & {N_REQ{en}};
    hs        = (state_q == OFFER) && ready;
    clr       = hs ? onehot3(code_q) : '0;
    pend_d    = (pend_q & ~clr) | fall;
    sel_mask  = (state_q == OFFER) ? pend_d : pend_q;
    sel_start = (hs ? code_q : last_grant_q) - CODE_W'(1);
  end

  prio_sel8 u_sel (
    .mask  (sel_mask),
    .start (sel_start),
    .rr    (ROUND_ROBIN != 0),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (en && sel_found) begin
          code_d  = sel_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          last_grant_d = code_q;
          if (en && sel_found) begin
            code_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_l_q      <= '1;
      pend_q       <= '0;
      code_q       <= '0;
      last_grant_q <= '0;
    end else begin
      state_q      <= state_d;
      req_l_q      <= req_l;
      pend_q       <= pend_d;
      code_q       <= code_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign code  = code_q;
  assign valid = (state_q == OFFER);
  assign pend  = pend_q;
  assign gs    = |pend_q;

endmodule

// File: doc/irq_encoder8x3.md
Name: irq_encoder8x3

Overview:
- Sequential 8-to-3 priority encoder.
- Captures falling edges on eight active-low request lines into a pending register. Encodes the winning request into a 3-bit code and offers it downstream on a valid/ready handshake.
- Encoder-side counterpart of the team's active-low-output 3-to-8 decoders; sits between request sources and the controller that services them.

Parameters:
- ROUND_ROBIN, 0, selection policy. 0 = fixed priority, index 7 highest. 1 = rotating priority, starting below the last granted index.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  active-high enable. Low blocks edge capture and new offers.
- req_l  input  8  active-low request lines, synchronous to clk
- code  output  3  encoded index of the offered request
- valid  output  1  code is valid
- ready  input  1  consumer accepts code when valid & ready
- pend  output  8  pending request bits, registered
- gs  output  1  group select: |pend (combinational from registers)

Behaviour:
- Reset values while rst_n is low (asynchronous): code=3'd0, valid=0, pend=8'h00, internal req_l_q=8'hFF, last_grant=3'd0, state=IDLE.
- Reset mid-offer drops valid immediately and discards all pending requests.
- Edge capture:
  - fall[i] = req_l_q[i] & ~req_l[i] & en; req_l_q <= req_l every cycle regardless of en.
  - A line held low generates exactly one event.
  - Events arriving while en=0 are lost; they are not deferred.
- Pending update each edge: pend <= (pend & ~clr) | fall.
  - clr is a one-hot of code when valid & ready, else 0.
  - Same-cycle fall and clr on the same bit: set wins, so a new event is never lost.
- Selector, ROUND_ROBIN=0: highest set index of the candidate mask.
- Selector, ROUND_ROBIN=1: first set index scanning downward from last_grant-1, mod 8, wrapping 0 -> 7.
  - last_grant updates to code on each handshake.
- State machine (2 states):
  - IDLE: valid=0. If en & gs, load code = select(pend) and go to OFFER; valid=1 on the next cycle.
  - OFFER: valid=1. code and valid are held stable while ready=0, independent of en and of new pending bits.
  - OFFER on handshake, next candidates = (pend & ~clr) | fall:
    - if en and candidates nonzero: load code = select(candidates), stay in OFFER. Back-to-back, one code per cycle.
    - else go to IDLE, valid=0.
- Latency: req_l falls and is sampled at edge k, so pend bit is set at edge k. In IDLE, valid=1 with the code at edge k+1.
- Output rules:
  - code is don't-care-free: it holds its last value when valid=0.
  - gs reflects pend, not valid.

Decomposition:
- Shared package irq_enc_pkg:
  - N_REQ=8, CODE_W=3
  - state enum {IDLE, OFFER}
  - function onehot3(code) returning the 8-bit clear mask
- Sub-module prio_sel8 (combinational):
  - inputs: mask[7:0], start[2:0], rr
  - outputs: idx[2:0], found
  - used once for the IDLE load and the OFFER reload.

Test Plan:
- Reset, then a single request:
  - rst_n low with req_l=8'hFF -> valid=0, pend=0, code=0, gs=0.
  - Release rst_n, drive req_l[5]=0 at edge k -> pend=8'h20 at k; valid=1, code=5 at k+1.
  - ready=1 -> next cycle pend=0, valid=0.
- Fixed priority with stall (ROUND_ROBIN=0):
  - Set bits 2, 6, 7 in one cycle with ready=0 -> code=7, held for 5 cycles.
  - Then ready=1 for 3 cycles -> codes 7, 6, 2 on consecutive cycles; valid drops after the third.
- Round robin (ROUND_ROBIN=1):
  - Keep pend at 8'hFF by re-pulsing each line after its grant (held-low lines produce no repeat event).
  - After grant of 4 -> next grants 3, 2, 1, 0, 7.
- Set-wins collision: while code=3 is being accepted, pulse req_l[3] high then low so fall[3] lands on the handshake cycle -> pend[3] stays 1 and code 3 is re-offered.
- Enable gating:
  - en=0, pulse req_l[1] -> pend unchanged, valid=0.
  - en=0 during an offer of code 4 with ready=0 -> valid stays 1, code=4.
  - After acceptance with en=0 -> IDLE even though gs=1.
- Async reset mid-offer: valid=1, pend=8'h81; assert rst_n low between clock edges -> valid and pend clear immediately, without waiting for a clock edge.
